// File: rtl/pinmux_pkg.sv
// Shared definitions for the pad attribute responder: attribute width,
// FSM state encoding and the pad-type write mask.
package pinmux_pkg;

  localparam int unsigned AttrWidth = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  // Bits a write may change for a given pad type; unlisted types are read-only.
  function automatic logic [AttrWidth-1:0] pad_type_mask(input int unsigned pad_type);
    logic [AttrWidth-1:0] mask;
    case (pad_type)
      32'd0:   mask = 8'hFF;
      32'd1:   mask = 8'h0F;
      32'd2:   mask = 8'h3F;
      default: mask = 8'h00;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/pad_attr_responder_if.sv
// Request/acknowledge bus between a requester and pad_attr_responder.
interface pad_attr_responder_if
  import pinmux_pkg::*;
;
  logic                 req_i;
  logic                 we_i;
  logic [4:0]           pad_idx_i;
  logic [AttrWidth-1:0] wdata_i;
  logic                 ack_o;
  logic [AttrWidth-1:0] rdata_o;
  logic                 err_o;
  logic                 busy_o;

  modport master (
    output req_i, we_i, pad_idx_i, wdata_i,
    input  ack_o, rdata_o, err_o, busy_o
  );

  modport slave (
    input  req_i, we_i, pad_idx_i, wdata_i,
    output ack_o, rdata_o, err_o, busy_o
  );
endinterface

// File: rtl/pad_attr_responder.sv
// Per-pad attribute register file behind a req/ack handshake with settle delay.
// Optional: PAD_ATTR_RESPONDER_READBACK_EN enables reads of stored attributes.
module pad_attr_responder
  import pinmux_pkg::*;
#(
  parameter int unsigned NumPads      = 4,
  parameter int unsigned PadType      = 0,
  parameter int unsigned SettleCycles = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  pad_attr_responder_if.slave            bus,
  output logic [AttrWidth*NumPads-1:0]   attr_o
);

  localparam logic [AttrWidth-1:0] WrMask = pad_type_mask(PadType);
  localparam bit                   NoSettle = (SettleCycles == 0);
  // APPLY lasts exactly SettleCycles cycles, so the counter starts one below.
  localparam logic [3:0] SettleLoad = NoSettle ? 4'd0 : 4'(SettleCycles - 1);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic [AttrWidth-1:0] rdata_q, rdata_d;
  logic                 idx_valid;
  logic                 wr_en;
  logic [AttrWidth-1:0] wr_val;

  assign idx_valid = (32'(bus.pad_idx_i) < NumPads);
  assign wr_val    = bus.wdata_i & WrMask;

  for (genvar n = 0; n < NumPads; n++) begin : g_pad
    logic [AttrWidth-1:0] pad_q, pad_d;

    always_comb begin
      if (wr_en && (bus.pad_idx_i == 5'(n))) begin
        pad_d = wr_val;
      end else begin
        pad_d = pad_q;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        pad_q <= 8'h00;
      end else begin
        pad_q <= pad_d;
      end
    end

    assign attr_o[n*AttrWidth +: AttrWidth] = pad_q;
  end

`ifdef PAD_ATTR_RESPONDER_READBACK_EN
  logic [AttrWidth-1:0] rd_val;

  always_comb begin
    rd_val = 8'h00;
    for (int n = 0; n < NumPads; n++) begin
      rd_val = rd_val | ((bus.pad_idx_i == 5'(n)) ? attr_o[n*AttrWidth +: AttrWidth] : 8'h00);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdata_d = 8'h00;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_i) begin
          if (!idx_valid) begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end else if (bus.we_i) begin
            wr_en = 1'b1;
            if (NoSettle) begin
              state_d = ST_ACK;
              ack_d   = 1'b1;
            end else begin
              state_d = ST_APPLY;
              cnt_d   = SettleLoad;
            end
          end else begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
`ifdef PAD_ATTR_RESPONDER_READBACK_EN
            rdata_d = rd_val;
`else
            err_d   = 1'b1;
`endif
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_APPLY: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Responses are registered alongside the state so they line up with ACK.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.ack_o   = ack_q;
  assign bus.err_o   = err_q;
  assign bus.busy_o  = busy_q;
  assign bus.rdata_o = rdata_q;

endmodule

// File: tb/tb_pad_attr_responder.sv
// Directed bench for pad_attr_responder: instance A (PadType 0, 3 settle
// cycles) and instance B (PadType 1, no settle).
module tb_pad_attr_responder;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [31:0] attr_a, attr_b;
  int          compared   = 0;
  int          mismatched = 0;

`ifdef PAD_ATTR_RESPONDER_READBACK_EN
  localparam bit ReadBack = 1'b1;
`else
  localparam bit ReadBack = 1'b0;
`endif

  always #5 clk = ~clk;

  pad_attr_responder_if bus_a ();
  pad_attr_responder_if bus_b ();

  pad_attr_responder #(.NumPads(4), .PadType(0), .SettleCycles(3)) dut_a (
    .clk_i (clk),
    .rst_i (rst_a),
    .bus   (bus_a),
    .attr_o(attr_a)
  );

  pad_attr_responder #(.NumPads(4), .PadType(1), .SettleCycles(0)) dut_b (
    .clk_i (clk),
    .rst_i (rst_b),
    .bus   (bus_b),
    .attr_o(attr_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req_a(input logic we, input logic [4:0] idx, input logic [7:0] data,
                       output int lat, output logic err, output logic [7:0] rd,
                       output logic [31:0] attr1);
    bus_a.req_i = 1'b1; bus_a.we_i = we; bus_a.pad_idx_i = idx; bus_a.wdata_i = data;
    lat = -1; err = 1'b0; rd = 8'h00; attr1 = 32'h0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) attr1 = attr_a;
      if (bus_a.ack_o === 1'b1) begin
        lat = c; err = bus_a.err_o; rd = bus_a.rdata_o;
        break;
      end
    end
    bus_a.req_i = 1'b0;
    tick();
  endtask

  task automatic req_b(input logic we, input logic [4:0] idx, input logic [7:0] data,
                       output int lat, output logic err, output logic [7:0] rd);
    bus_b.req_i = 1'b1; bus_b.we_i = we; bus_b.pad_idx_i = idx; bus_b.wdata_i = data;
    lat = -1; err = 1'b0; rd = 8'h00;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus_b.ack_o === 1'b1) begin
        lat = c; err = bus_b.err_o; rd = bus_b.rdata_o;
        break;
      end
    end
    bus_b.req_i = 1'b0;
    tick();
  endtask

  initial begin
    int          lat;
    logic        err;
    logic [7:0]  rd;
    logic [31:0] attr1;
    bit          ack_seen;

    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.req_i = 1'b0; bus_a.we_i = 1'b0; bus_a.pad_idx_i = 5'd0; bus_a.wdata_i = 8'h00;
    bus_b.req_i = 1'b0; bus_b.we_i = 1'b0; bus_b.pad_idx_i = 5'd0; bus_b.wdata_i = 8'h00;
    tick(); tick();
    check("rst_ack",   {31'd0, bus_a.ack_o},  32'd0);
    check("rst_busy",  {31'd0, bus_a.busy_o}, 32'd0);
    check("rst_err",   {31'd0, bus_a.err_o},  32'd0);
    check("rst_rdata", {24'd0, bus_a.rdata_o}, 32'd0);
    check("rst_attr_a", attr_a, 32'h0000_0000);
    check("rst_attr_b", attr_b, 32'h0000_0000);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

    // Write pad 2 = 0xA5 on A: visible next cycle, ack after 4 cycles.
    req_a(1'b1, 5'd2, 8'hA5, lat, err, rd, attr1);
    check("wr2_attr_next", attr1, 32'h00A5_0000);
    check("wr2_latency", 32'(lat), 32'd4);
    check("wr2_err", {31'd0, err}, 32'd0);
    check("wr2_busy_idle", {31'd0, bus_a.busy_o}, 32'd0);

    req_a(1'b0, 5'd2, 8'h00, lat, err, rd, attr1);
    check("rd2_latency", 32'(lat), 32'd1);
    check("rd2_rdata", {24'd0, rd}, ReadBack ? 32'h0000_00A5 : 32'h0000_0000);
    check("rd2_err", {31'd0, err}, ReadBack ? 32'd0 : 32'd1);

    // Out-of-range pad: immediate error ack, no register change.
    req_a(1'b1, 5'd5, 8'h12, lat, err, rd, attr1);
    check("oob_latency", 32'(lat), 32'd1);
    check("oob_err", {31'd0, err}, 32'd1);
    check("oob_rdata", {24'd0, rd}, 32'd0);
    check("oob_attr", attr_a, 32'h00A5_0000);

    req_a(1'b1, 5'd0, 8'h3C, lat, err, rd, attr1);
    check("wr0_latency", 32'(lat), 32'd4);
    check("wr0_attr", attr_a, 32'h00A5_003C);

    // B: PadType 1 masks to 0x0F, no settle.
    req_b(1'b1, 5'd0, 8'hFF, lat, err, rd);
    check("b_wr0_latency", 32'(lat), 32'd1);
    check("b_wr0_err", {31'd0, err}, 32'd0);
    check("b_wr0_attr", attr_b, 32'h0000_000F);

    req_b(1'b0, 5'd0, 8'h00, lat, err, rd);
    check("b_rd0_latency", 32'(lat), 32'd1);
    check("b_rd0_rdata", {24'd0, rd}, ReadBack ? 32'h0000_000F : 32'h0000_0000);
    check("b_rd0_err", {31'd0, err}, ReadBack ? 32'd0 : 32'd1);

    // B: request held through ACK is taken again in the following IDLE cycle.
    bus_b.req_i = 1'b1; bus_b.we_i = 1'b1; bus_b.pad_idx_i = 5'd1; bus_b.wdata_i = 8'h3C;
    tick();
    check("b_hold_ack1", {31'd0, bus_b.ack_o}, 32'd1);
    check("b_hold_attr1", attr_b, 32'h0000_0C0F);
    bus_b.wdata_i = 8'h5A;
    tick();
    check("b_hold_idle_ack", {31'd0, bus_b.ack_o}, 32'd0);
    check("b_hold_idle_busy", {31'd0, bus_b.busy_o}, 32'd0);
    tick();
    check("b_hold_ack2", {31'd0, bus_b.ack_o}, 32'd1);
    check("b_hold_attr2", attr_b, 32'h0000_0A0F);
    bus_b.req_i = 1'b0;
    tick();

    // A: reset during APPLY aborts the write and clears the pads.
    bus_a.req_i = 1'b1; bus_a.we_i = 1'b1; bus_a.pad_idx_i = 5'd3; bus_a.wdata_i = 8'h77;
    tick();
    check("abort_attr_written", attr_a, 32'h77A5_003C);
    check("abort_busy", {31'd0, bus_a.busy_o}, 32'd1);
    bus_a.req_i = 1'b0;
    tick();
    rst_a = 1'b1;
    tick();
    check("abort_rst_busy", {31'd0, bus_a.busy_o}, 32'd0);
    check("abort_rst_ack", {31'd0, bus_a.ack_o}, 32'd0);
    check("abort_rst_attr", attr_a, 32'h0000_0000);
    rst_a = 1'b0;
    ack_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus_a.ack_o !== 1'b0) ack_seen = 1'b1;
    end
    check("abort_no_ack", {31'd0, ack_seen}, 32'd0);
    check("abort_attr_after", attr_a, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
